// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Target end of the processor data-memory interface. Each rising
//             edge of MemRead/MemWrite starts one word request. The request
//             waits WAIT_CYCLES wait states and then reads or writes the
//             internal word RAM. Completion is a one-cycle mem_ready pulse,
//             and mem_error rises with it when the request was illegal.
//  Ports    : clk        - clock, all state updates on the rising edge
//             rst        - asynchronous reset, active low
//             MemRead    - read strobe (level; its rising edge is a request)
//             MemWrite   - write strobe (level; its rising edge is a request)
//             dAddress   - byte address
//             dWriteData - write data
//             dReadData  - registered read data, held until the next good read
//             mem_ready  - one-cycle completion pulse
//             mem_error  - high together with mem_ready for an illegal access
//             busy       - high from accept until mem_ready
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        mem_ready,
    output logic        mem_error,
    output logic        busy
);

    localparam int          c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_SPAN  = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  c_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_rd_q;
    logic                r_wr_q;
    logic                r_op_rd;
    logic                r_op_wr;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_cnt;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_rd_rise;
    logic                w_wr_rise;
    logic                w_req;
    logic [31:0]         w_off;
    logic                w_legal;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_accept;
    logic                w_access;
    logic                w_cnt_dec;
    logic                w_done;

    // A request is a strobe edge, so a strobe held high yields one request.
    assign w_rd_rise = MemRead  & ~r_rd_q;
    assign w_wr_rise = MemWrite & ~r_wr_q;
    assign w_req     = w_rd_rise | w_wr_rise;

    // The subtraction wraps, so addresses below the base become huge offsets
    // and fail the range test instead of aliasing onto low words.
    assign w_off   = r_addr - BASE_ADDR;
    assign w_legal = (r_addr[1:0] == 2'b00) && (w_off < c_SPAN) &&
                     !(r_op_rd && r_op_wr);
    assign w_idx   = w_off[c_IDX_W+1:2];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        w_cnt_dec   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_dec   = 1'b1;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, wait counter and response outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_q    <= 1'b0;
            r_wr_q    <= 1'b0;
            r_op_rd   <= 1'b0;
            r_op_wr   <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_cnt     <= 4'd0;
            dReadData <= 32'd0;
            mem_ready <= 1'b0;
            mem_error <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Strobe history tracks every cycle so edges during WAIT/DONE
            // are consumed rather than replayed once the block is idle.
            r_rd_q <= MemRead;
            r_wr_q <= MemWrite;

            if (w_accept) begin
                r_op_rd <= w_rd_rise;
                r_op_wr <= w_wr_rise;
                r_addr  <= dAddress;
                r_wdata <= dWriteData;
                r_cnt   <= c_WAIT;
                busy    <= 1'b1;
            end

            if (w_cnt_dec) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_access) begin
                mem_ready <= 1'b1;
                mem_error <= ~w_legal;
                busy      <= 1'b0;
                if (w_legal && r_op_rd) begin
                    dReadData <= r_mem[w_idx];
                end
            end

            if (w_done) begin
                mem_ready <= 1'b0;
                mem_error <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word RAM (contents survive reset; a write only commits on the access
    // edge, so a reset during WAIT abandons it)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_access && w_legal && r_op_wr) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder. Instance A uses two
//             wait states, instance B uses none. Directed table vectors,
//             multi-cycle corner sequences and random traffic are checked
//             against a word-array reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 16;
    localparam int          WA    = 2;

    logic        clk;
    logic        rst;

    logic        a_rd, a_wr, a_rdy, a_err, a_busy;
    logic [31:0] a_addr, a_wd, a_rdata;
    logic        b_rd, b_wr, b_rdy, b_err, b_busy;
    logic [31:0] b_addr, b_wd, b_rdata;

    int tests = 0;
    int fails = 0;

    // reference model
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rdata;

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        tbl [16];
    logic        g_err;
    logic [31:0] g_rd;
    int          pulses;

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WA)) u_a (
        .clk(clk), .rst(rst), .MemRead(a_rd), .MemWrite(a_wr),
        .dAddress(a_addr), .dWriteData(a_wd), .dReadData(a_rdata),
        .mem_ready(a_rdy), .mem_error(a_err), .busy(a_busy)
    );

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .MemRead(b_rd), .MemWrite(b_wr),
        .dAddress(b_addr), .dWriteData(b_wd), .dReadData(b_rdata),
        .mem_ready(b_rdy), .mem_error(b_err), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One request on instance A, checked against the model: latency,
    // busy during the wait, error flag, read data and pulse width.
    task automatic run_op(input string nm, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic got_err, output logic [31:0] got_rd);
        logic [31:0] off;
        logic        legal;
        int          idx;
        int          lat;
        logic        busy_ok;
        off     = a - BASE;
        legal   = (a % 4 == 0) && (off < 32'(4 * DEPTH)) && !(r && w);
        idx     = int'(off / 4);
        lat     = -1;
        busy_ok = 1'b1;
        got_err = 1'b0;
        got_rd  = a_rdata;
        @(negedge clk);
        a_rd = r; a_wr = w; a_addr = a; a_wd = d;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a_rd = 1'b0; a_wr = 1'b0;
            end
            if (a_rdy) begin
                lat     = k;
                got_err = a_err;
                got_rd  = a_rdata;
                if (a_busy) busy_ok = 1'b0;
                break;
            end else if (!a_busy) begin
                busy_ok = 1'b0;
            end
        end
        if (legal && w) m_mem[idx] = d;
        if (legal && r) m_rdata = m_mem[idx];
        chk({nm, " latency"}, 32'(lat), 32'(WA + 2));
        chk({nm, " busy"}, 32'(busy_ok), 32'd1);
        chk({nm, " err"}, 32'(got_err), 32'(!legal));
        chk({nm, " rdata"}, got_rd, m_rdata);
        @(negedge clk);
        chk({nm, " pulse width"}, 32'(a_rdy), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] ad;
        logic        r, w;
        int          sel;

        // Directed vectors, expectations worked out by hand
        tbl[0]  = '{r:1'b0, w:1'b1, addr:BASE + 32'd8,  data:32'hCAFEF00D, exp_err:1'b0, exp_rd:32'h00000000};
        tbl[1]  = '{r:1'b1, w:1'b0, addr:BASE + 32'd8,  data:32'h0,        exp_err:1'b0, exp_rd:32'hCAFEF00D};
        tbl[2]  = '{r:1'b0, w:1'b1, addr:BASE,          data:32'h12345678, exp_err:1'b0, exp_rd:32'hCAFEF00D};
        tbl[3]  = '{r:1'b1, w:1'b0, addr:BASE + 32'd2,  data:32'h0,        exp_err:1'b1, exp_rd:32'hCAFEF00D};
        tbl[4]  = '{r:1'b0, w:1'b1, addr:BASE + 32'd64, data:32'h00000001, exp_err:1'b1, exp_rd:32'hCAFEF00D};
        tbl[5]  = '{r:1'b1, w:1'b0, addr:BASE,          data:32'h0,        exp_err:1'b0, exp_rd:32'h12345678};
        tbl[6]  = '{r:1'b0, w:1'b1, addr:BASE + 32'd12, data:32'h0BADBEEF, exp_err:1'b0, exp_rd:32'h12345678};
        tbl[7]  = '{r:1'b1, w:1'b1, addr:BASE + 32'd12, data:32'h00000055, exp_err:1'b1, exp_rd:32'h12345678};
        tbl[8]  = '{r:1'b1, w:1'b0, addr:BASE + 32'd12, data:32'h0,        exp_err:1'b0, exp_rd:32'h0BADBEEF};
        tbl[9]  = '{r:1'b1, w:1'b0, addr:BASE - 32'd4,  data:32'h0,        exp_err:1'b1, exp_rd:32'h0BADBEEF};
        tbl[10] = '{r:1'b1, w:1'b0, addr:BASE + 32'd60, data:32'h0,        exp_err:1'b0, exp_rd:32'h00000000};
        tbl[11] = '{r:1'b0, w:1'b1, addr:BASE + 32'd60, data:32'hFFFF0001, exp_err:1'b0, exp_rd:32'h00000000};
        tbl[12] = '{r:1'b1, w:1'b0, addr:BASE + 32'd60, data:32'h0,        exp_err:1'b0, exp_rd:32'hFFFF0001};
        tbl[13] = '{r:1'b1, w:1'b0, addr:BASE + 32'd64, data:32'h0,        exp_err:1'b1, exp_rd:32'hFFFF0001};
        tbl[14] = '{r:1'b0, w:1'b1, addr:BASE + 32'd72, data:32'h00000077, exp_err:1'b1, exp_rd:32'hFFFF0001};
        tbl[15] = '{r:1'b1, w:1'b0, addr:BASE + 32'd8,  data:32'h0,        exp_err:1'b0, exp_rd:32'hCAFEF00D};

        a_rd = 0; a_wr = 0; a_addr = 0; a_wd = 0;
        b_rd = 0; b_wr = 0; b_addr = 0; b_wd = 0;
        m_rdata = 32'd0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset A rdata", a_rdata, 32'd0);
        chk("reset A ready", 32'(a_rdy), 32'd0);
        chk("reset A err", 32'(a_err), 32'd0);
        chk("reset A busy", 32'(a_busy), 32'd0);
        chk("reset B rdata", b_rdata, 32'd0);
        chk("reset B busy", 32'(b_busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Give every word a known value
        for (int i = 0; i < DEPTH; i++)
            run_op($sformatf("init%0d", i), 1'b0, 1'b1, BASE + 32'(4 * i), 32'd0, g_err, g_rd);

        // Table-driven directed vectors
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].r, tbl[i].w, tbl[i].addr, tbl[i].data, g_err, g_rd);
            chk($sformatf("tbl%0d exp err", i), 32'(g_err), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d exp rdata", i), g_rd, tbl[i].exp_rd);
        end

        // Read strobe held high for 10 cycles: one completion only
        @(negedge clk);
        a_rd = 1'b1; a_addr = BASE + 32'd8;
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 9) a_rd = 1'b0;
            if (a_rdy) pulses++;
        end
        m_rdata = m_mem[2];
        chk("held strobe pulses", 32'(pulses), 32'd1);
        chk("held strobe rdata", a_rdata, m_rdata);

        // Second rising edge while in WAIT is dropped
        @(negedge clk);
        a_rd = 1'b1; a_addr = BASE + 32'd12;
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            a_rd = (k == 1);
            if (a_rdy) pulses++;
        end
        m_rdata = m_mem[3];
        chk("re-edge in WAIT pulses", 32'(pulses), 32'd1);
        chk("re-edge in WAIT rdata", a_rdata, m_rdata);

        // Reset during WAIT abandons a write
        run_op("pre-reset write", 1'b0, 1'b1, BASE + 32'd16, 32'h00001111, g_err, g_rd);
        @(negedge clk);
        a_wr = 1'b1; a_addr = BASE + 32'd16; a_wd = 32'hAAAA5555;
        @(negedge clk);
        a_wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async reset rdata", a_rdata, 32'd0);
        chk("async reset busy", 32'(a_busy), 32'd0);
        chk("async reset ready", 32'(a_rdy), 32'd0);
        chk("async reset err", 32'(a_err), 32'd0);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (a_rdy) pulses++;
        end
        chk("no ready in reset", 32'(pulses), 32'd0);
        rst = 1'b1;
        m_rdata = 32'd0;
        run_op("post-reset read", 1'b1, 1'b0, BASE + 32'd16, 32'd0, g_err, g_rd);
        chk("abandoned write", g_rd, 32'h00001111);

        // Zero wait states, a new request every 3 cycles
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            b_wr = (j < 4); b_rd = (j >= 4);
            b_addr = BASE + 32'(4 * (j % 4));
            b_wd = 32'h600D0000 + 32'(j);
            @(negedge clk);
            b_rd = 1'b0; b_wr = 1'b0;
            chk($sformatf("w0 req%0d early ready", j), 32'(b_rdy), 32'd0);
            @(negedge clk);
            chk($sformatf("w0 req%0d ready", j), 32'(b_rdy), 32'd1);
            chk($sformatf("w0 req%0d err", j), 32'(b_err), 32'd0);
            if (j >= 4)
                chk($sformatf("w0 req%0d rdata", j), b_rdata, 32'h600D0000 + 32'(j - 4));
        end

        // Random traffic against the model
        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3, 4, 5: ad = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                6:       ad = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
                7:       ad = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
                8:       ad = BASE - 32'(4 * $urandom_range(1, 100));
                default: ad = $urandom;
            endcase
            sel = int'($urandom_range(0, 9));
            r = (sel <= 4) || (sel == 9);
            w = (sel >= 5);
            run_op($sformatf("rnd%0d", n), r, w, ad, $urandom, g_err, g_rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
